fc_phase_aligner: RTL and testbench
===================================

# fc_phase_aligner

Parametrised successor to the fixed fast-command/clock delay stage in the ETROC2 fast-command front end. It combines four functions in the clk320 domain: a programmable digital delay line for the serial fast-command bit (fc), an 8-bit word deserialiser, and an automatic word-boundary alignment state machine that locks on the IDLE pattern. It also monitors alignment and drops lock when it is lost. It sits between the fc input pad and the fast-command decoder, replacing the single on/off delay cell with a selectable tap and bit-slip alignment.

## Interface
Parameters:
- DELAY_DEPTH, 16: number of delay taps (power of 2, ≥2); tap select width DW = log2(DELAY_DEPTH).
- IDLE_PATTERN, 8'hF0: IDLE fast-command word used for alignment.
- LOCK_COUNT, 4: consecutive IDLE words needed to lock (1..15).
- UNLOCK_COUNT, 4: consecutive misaligned-IDLE words needed to unlock (1..15).

Ports:
- clk320 in 1: 320 MHz bit clock; the only clock.
- rstn in 1: asynchronous, active-low reset.
- fc in 1: serial fast-command bit, one bit per clk320 rising edge.
- delaySel in DW: delay tap select.
- autoAlign in 1: 1 enables the alignment FSM.
- fcOut out 1: delayed serial bit.
- word out 8: deserialised word; MSB is the earliest bit received.
- wordValid out 1: one-cycle strobe when word updates.
- locked out 1: alignment achieved.
- bitPhase out 3: number of slips applied so far, mod 8.
- errCount out 8: saturating count of misaligned-IDLE words seen while locked.

## Operation
- Delay line: dly[0] <= fc; dly[i] <= dly[i-1]. fcOut = dly[delaySel], a combinational mux of registered taps.
- Deserialiser: sr shifts in fcOut every cycle.
  - A 3-bit counter cnt increments every cycle unless slip=1, in which case it holds for exactly one cycle.
  - On any cycle with cnt==7 and no slip: word <= {sr[6:0], fcOut} and wordValid <= 1. On all other cycles wordValid <= 0.
- Misaligned IDLE: any of the 7 non-identity bit rotations of IDLE_PATTERN. For 8'hF0 these are 78, 3C, 1E, 0F, 87, C3, E1.
- FSM states and transitions:
  - SEARCH, new word == IDLE: goodCnt++. When goodCnt reaches LOCK_COUNT → LOCKED.
  - SEARCH, new word != IDLE: goodCnt=0; assert slip for the next cycle; bitPhase++ (wraps 7→0).
  - LOCKED, misaligned-IDLE word: badCnt++ and errCount++ (saturates at 255). When badCnt reaches UNLOCK_COUNT → SEARCH with goodCnt=0; no slip is issued on this transition.
  - LOCKED, any other word (IDLE or a command): badCnt=0.
- autoAlign=0: FSM is forced to SEARCH; slip is never asserted; goodCnt and badCnt are held at 0; locked=0. The deserialiser keeps running. bitPhase and errCount are held.
- Deasserting autoAlign while LOCKED drops lock on the next cycle.
- locked = (state==LOCKED), registered.

## Timing
- Reset value of every output is 0: fcOut, word, wordValid, locked, bitPhase, errCount. Internal cnt, sr, dly, goodCnt, badCnt and slip also reset to 0; the FSM resets to SEARCH.
- fc sampled at edge t appears on fcOut during cycle t+1+delaySel. A change of delaySel takes effect in the same cycle (combinational mux), so bits may be skipped or repeated; the user must realign after changing it.
- Word latency: the last bit of a word is on fcOut at edge e; word and wordValid are valid after edge e.
- wordValid period is 8 cycles, or 9 cycles across a slip.
- locked rises on the same edge that the LOCK_COUNT-th IDLE word loads.
- locked falls on the same edge that the UNLOCK_COUNT-th misaligned word loads.
- Slip is decided on a boundary edge and takes effect on the following cycle. Only one slip can be in flight, since boundaries are ≥8 cycles apart.
- Asynchronous reset mid-operation clears everything immediately, including an in-flight slip; alignment restarts from SEARCH.

## Test plan
- Reset: hold rstn=0 with random fc → all outputs 0. Release → wordValid first pulses 8 cycles after release; locked=0.
- Delay taps: autoAlign=0, delaySel=5, single fc pulse sampled at edge 10 → fcOut=1 during cycle 16 only. Repeat for delaySel=0 and DELAY_DEPTH-1.
- Alignment: continuous IDLE stream offset by 3 bits, autoAlign=1 → slips until word==F0, ending with bitPhase=3 or 5 depending on slip direction (check against model). Then locked=1 after 4 consecutive F0 words, and wordValid pulses every 8 cycles thereafter.
- Command words while locked: inject 8'h96, 8'h5A, then IDLE → locked stays 1, errCount stays 0, and word shows 96, 5A, F0 in order.
- Loss of lock: after lock, insert one extra bit into the stream → 4 misaligned words; errCount=4; locked drops on the 4th; FSM re-slips and re-locks with bitPhase advanced by the required slips.
- Mid-search reset and autoAlign=0: assert rstn=0 during a slip cycle → clean restart. Separately, drive autoAlign 1→0 while locked → locked=0 the next cycle, no further slips, and bitPhase holds.

Source files
------------

// File: rtl/fc_phase_aligner.sv
// fc_phase_aligner
//   Fast-command front end in the clk320 domain. It delays the serial fc bit
//   through a tap-selectable delay line, deserialises it into 8-bit words and,
//   when autoAlign is set, slips the word boundary until the IDLE pattern is
//   seen, then watches for lost alignment.
//
// Ports
//   clk320    : bit clock, one fc bit per rising edge
//   rstn      : asynchronous active-low reset
//   fc        : serial fast-command bit
//   delaySel  : delay tap select, fcOut = tap[delaySel]
//   autoAlign : enables the alignment FSM
//   fcOut     : delayed serial bit
//   word      : deserialised word, MSB received first
//   wordValid : one-cycle strobe when word updates
//   locked    : word boundary aligned to IDLE
//   bitPhase  : slips applied so far, mod 8
//   errCount  : saturating count of misaligned IDLE words seen while locked
//
// FSM states
//   state  | meaning
//   SEARCH | hunting for IDLE; every non-IDLE word costs one bit slip
//   LOCKED | aligned; counting consecutive rotated-IDLE words
module fc_phase_aligner #(
  parameter int         DELAY_DEPTH  = 16,
  parameter logic [7:0] IDLE_PATTERN = 8'hF0,
  parameter int         LOCK_COUNT   = 4,
  parameter int         UNLOCK_COUNT = 4,
  localparam int        DW           = $clog2(DELAY_DEPTH)
) (
  input  logic          clk320,
  input  logic          rstn,
  input  logic          fc,
  input  logic [DW-1:0] delaySel,
  input  logic          autoAlign,
  output logic          fcOut,
  output logic [7:0]    word,
  output logic          wordValid,
  output logic          locked,
  output logic [2:0]    bitPhase,
  output logic [7:0]    errCount
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} stateT;

  localparam logic [3:0] LOCK_LAST   = 4'(LOCK_COUNT - 1);
  localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_COUNT - 1);

  logic [DELAY_DEPTH-1:0] dly;
  logic [6:0]             sr;
  logic [2:0]             cnt;
  logic                   slip;
  logic [3:0]             goodCnt;
  logic [3:0]             badCnt;
  stateT                  state;

  stateT      stateNext;
  logic [3:0] goodNext;
  logic [3:0] badNext;
  logic       slipNext;
  logic [2:0] phaseNext;
  logic [7:0] errNext;
  logic [7:0] newWord;
  logic       boundary;

  // A rotation that happens to equal IDLE itself (symmetric patterns) is
  // treated as aligned, not as an error.
  function automatic logic isMisaligned(input logic [7:0] w);
    logic       hit;
    logic [7:0] rot;
    hit = 1'b0;
    for (int r = 1; r < 8; r++) begin
      rot = (IDLE_PATTERN << r) | (IDLE_PATTERN >> (8 - r));
      if ((w == rot) && (w != IDLE_PATTERN)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign fcOut    = dly[delaySel];
  assign newWord  = {sr, fcOut};
  // A pending slip freezes cnt for one cycle, which also masks the boundary.
  assign boundary = (cnt == 3'd7) && !slip;
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk320 or negedge rstn) begin
    if (!rstn) begin
      dly       <= '0;
      sr        <= '0;
      cnt       <= '0;
      word      <= '0;
      wordValid <= 1'b0;
    end else begin
      dly       <= {dly[DELAY_DEPTH-2:0], fc};
      sr        <= newWord[6:0];
      wordValid <= boundary;
      if (!slip) cnt <= cnt + 3'd1;
      if (boundary) word <= newWord;
    end
  end

  always_ff @(posedge clk320 or negedge rstn) begin
    if (!rstn) begin
      state    <= SEARCH;
      goodCnt  <= '0;
      badCnt   <= '0;
      slip     <= 1'b0;
      bitPhase <= '0;
      errCount <= '0;
    end else begin
      state    <= stateNext;
      goodCnt  <= goodNext;
      badCnt   <= badNext;
      slip     <= slipNext;
      bitPhase <= phaseNext;
      errCount <= errNext;
    end
  end

  always_comb begin
    stateNext = state;
    goodNext  = goodCnt;
    badNext   = badCnt;
    slipNext  = 1'b0;
    phaseNext = bitPhase;
    errNext   = errCount;
    if (!autoAlign) begin
      stateNext = SEARCH;
      goodNext  = '0;
      badNext   = '0;
    end else if (boundary) begin
      case (state)
        SEARCH: begin
          if (newWord == IDLE_PATTERN) begin
            if (goodCnt == LOCK_LAST) begin
              stateNext = LOCKED;
              goodNext  = '0;
            end else begin
              goodNext = goodCnt + 4'd1;
            end
          end else begin
            goodNext  = '0;
            slipNext  = 1'b1;
            phaseNext = bitPhase + 3'd1;
          end
        end
        LOCKED: begin
          if (isMisaligned(newWord)) begin
            if (errCount != 8'hFF) errNext = errCount + 8'd1;
            if (badCnt == UNLOCK_LAST) begin
              // Dropping lock does not slip; the next SEARCH word decides.
              stateNext = SEARCH;
              badNext   = '0;
              goodNext  = '0;
            end else begin
              badNext = badCnt + 4'd1;
            end
          end else begin
            badNext = '0;
          end
        end
        default: stateNext = SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_phase_aligner.sv
module tb_fc_phase_aligner;
  localparam int         DEPTH  = 16;
  localparam int         DW     = 4;
  localparam logic [7:0] IDLE   = 8'hF0;
  localparam int         LOCKN  = 4;
  localparam int         UNLOCKN = 4;

  logic          clk320 = 1'b0;
  logic          rstn = 1'b1;
  logic          fc = 1'b0;
  logic [DW-1:0] delaySel = '0;
  logic          autoAlign = 1'b0;
  logic          fcOut;
  logic [7:0]    word;
  logic          wordValid;
  logic          locked;
  logic [2:0]    bitPhase;
  logic [7:0]    errCount;

  int vectors = 0;
  int miscompares = 0;

  fc_phase_aligner dut (
    .clk320(clk320), .rstn(rstn), .fc(fc), .delaySel(delaySel),
    .autoAlign(autoAlign), .fcOut(fcOut), .word(word), .wordValid(wordValid),
    .locked(locked), .bitPhase(bitPhase), .errCount(errCount)
  );

  always #5 clk320 = ~clk320;

  // Reference model: a word is the last 8 received bits, taken every 8 bits
  // (9 after a slip decision); alignment rules applied per word.
  logic [DEPTH-1:0] mHist;
  logic [7:0]       mRx;
  logic [7:0]       mWord;
  int               mBits, mWordLen, mGood, mBad, mPhase, mErr;
  bit               mValid, mLocked;

  bit         txQ[$];
  int         idlePos = 0;
  logic [7:0] idleWord = IDLE;

  function automatic bit isRot(logic [7:0] w);
    logic [15:0] dbl;
    dbl = {IDLE, IDLE};
    for (int r = 1; r < 8; r++)
      if (w == dbl[15-r -: 8] && w != IDLE) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    mHist = '0; mRx = '0; mWord = '0; mBits = 0; mWordLen = 8;
    mGood = 0; mBad = 0; mPhase = 0; mErr = 0; mValid = 0; mLocked = 0;
  endtask

  task automatic step();
    bit rxBit;
    rxBit = mHist[delaySel];
    mRx = {mRx[6:0], rxBit};
    mBits++;
    mValid = 0;
    if (mBits == mWordLen) begin
      mBits = 0; mWordLen = 8; mWord = mRx; mValid = 1;
      if (autoAlign) begin
        if (!mLocked) begin
          if (mRx == IDLE) begin
            mGood++;
            if (mGood == LOCKN) begin mLocked = 1; mGood = 0; end
          end else begin
            mGood = 0; mWordLen = 9; mPhase = (mPhase + 1) % 8;
          end
        end else if (isRot(mRx)) begin
          mBad++;
          if (mErr < 255) mErr++;
          if (mBad == UNLOCKN) begin mLocked = 0; mBad = 0; mGood = 0; end
        end else begin
          mBad = 0;
        end
      end
    end
    if (!autoAlign) begin mLocked = 0; mGood = 0; mBad = 0; end
    mHist = {mHist[DEPTH-2:0], fc};
    @(posedge clk320); #1;
  endtask

  task automatic txStep();
    if (txQ.size() > 0) fc = txQ.pop_front();
    else begin
      fc = idleWord[7-idlePos];
      idlePos = (idlePos + 1) % 8;
    end
    step();
  endtask

  task automatic pushWord(logic [7:0] w);
    for (int i = 7; i >= 0; i--) txQ.push_back(w[i]);
  endtask

  task automatic test_reset();
    autoAlign = 0; delaySel = '0;
    for (int i = 0; i < 6; i++) begin
      fc = 1'($urandom); @(posedge clk320); #1;
      vectors++;
      if ({fcOut, word, wordValid, locked, bitPhase, errCount} !== 22'd0) begin
        miscompares++;
        $display("FAIL reset_hold: got %h want 0", {fcOut, word, wordValid, locked, bitPhase, errCount});
      end
    end
    #2 rstn = 1'b1;
    modelReset();
    for (int k = 1; k <= 10; k++) begin
      fc = 1'($urandom); step();
      vectors++;
      if (wordValid !== 1'(k == 8) || locked !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_first_valid: cycle %0d got valid=%b locked=%b want valid=%b locked=0", k, wordValid, locked, (k == 8));
      end
    end
  endtask

  task automatic test_delay(int d);
    autoAlign = 0; delaySel = DW'(d); fc = 0;
    for (int i = 0; i < DEPTH + 1; i++) step();
    fc = 1; step(); fc = 0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      vectors++;
      if (fcOut !== 1'(k == d)) begin
        miscompares++;
        $display("FAIL delay_tap%0d: %0d cycles after sample got %b want %b", d, k, fcOut, (k == d));
      end
      vectors++;
      if ({fcOut, word, wordValid, locked, bitPhase, errCount} !==
          {mHist[delaySel], mWord, mValid, mLocked, 3'(mPhase), 8'(mErr)}) begin
        miscompares++;
        $display("FAIL delay_state: got %h want %h", {fcOut, word, wordValid, locked, bitPhase, errCount},
                 {mHist[delaySel], mWord, mValid, mLocked, 3'(mPhase), 8'(mErr)});
      end
      step();
    end
  endtask

  task automatic test_align();
    bit done;
    int last;
    done = 0; last = -1;
    autoAlign = 1; delaySel = DW'($urandom_range(0, DEPTH-1));
    txQ.delete(); idlePos = 3;
    for (int i = 0; i < 400 && !done; i++) begin
      txStep();
      vectors++;
      if ({fcOut, word, wordValid, locked, bitPhase, errCount} !==
          {mHist[delaySel], mWord, mValid, mLocked, 3'(mPhase), 8'(mErr)}) begin
        miscompares++;
        $display("FAIL align_state: got %h want %h", {fcOut, word, wordValid, locked, bitPhase, errCount},
                 {mHist[delaySel], mWord, mValid, mLocked, 3'(mPhase), 8'(mErr)});
      end
      if (mLocked) done = 1;
    end
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL align_lock: got locked=%b want 1 within 400 cycles", locked);
    end
    for (int i = 0; i < 40; i++) begin
      txStep();
      if (wordValid === 1'b1) begin
        vectors++;
        if (word !== IDLE) begin
          miscompares++;
          $display("FAIL align_word: got %h want %h", word, IDLE);
        end
        if (last >= 0) begin
          vectors++;
          if (i - last != 8) begin
            miscompares++;
            $display("FAIL align_period: got %0d want 8", i - last);
          end
        end
        last = i;
      end
    end
  endtask

  task automatic test_commands();
    logic [7:0] cmd;
    logic [7:0] seen[$];
    bit found;
    found = 0;
    cmd = 8'($urandom);
    if (isRot(cmd) || cmd == IDLE) cmd = 8'h3A;
    for (int i = 0; i < 8 && idlePos != 0; i++) txStep();
    pushWord(8'h96); pushWord(8'h5A); pushWord(IDLE); pushWord(cmd);
    for (int i = 0; i < 80; i++) begin
      txStep();
      if (wordValid === 1'b1) seen.push_back(word);
      vectors++;
      if (locked !== 1'b1 || errCount !== 8'd0) begin
        miscompares++;
        $display("FAIL cmd_locked: got locked=%b err=%0d want locked=1 err=0", locked, errCount);
      end
    end
    for (int j = 0; j + 3 < seen.size(); j++)
      if (seen[j] == 8'h96 && seen[j+1] == 8'h5A && seen[j+2] == IDLE && seen[j+3] == cmd) found = 1;
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL cmd_sequence: got %0d words without 96 5A F0 %h in order, want it present", seen.size(), cmd);
    end
  endtask

  task automatic test_lose_lock();
    int p0;
    bit sawDrop, relocked;
    p0 = mPhase; sawDrop = 0; relocked = 0;
    txQ.push_back(1'b0);
    for (int i = 0; i < 300 && !relocked; i++) begin
      txStep();
      vectors++;
      if ({fcOut, word, wordValid, locked, bitPhase, errCount} !==
          {mHist[delaySel], mWord, mValid, mLocked, 3'(mPhase), 8'(mErr)}) begin
        miscompares++;
        $display("FAIL unlock_state: got %h want %h", {fcOut, word, wordValid, locked, bitPhase, errCount},
                 {mHist[delaySel], mWord, mValid, mLocked, 3'(mPhase), 8'(mErr)});
      end
      if (locked === 1'b0) sawDrop = 1;
      if (sawDrop && mLocked) relocked = 1;
    end
    vectors++;
    if (!sawDrop || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL unlock_relock: got dropped=%b locked=%b want dropped=1 locked=1", sawDrop, locked);
    end
    vectors++;
    if (errCount !== 8'd4) begin
      miscompares++;
      $display("FAIL unlock_errcount: got %0d want 4", errCount);
    end
    vectors++;
    if (bitPhase !== 3'((p0 + 1) % 8)) begin
      miscompares++;
      $display("FAIL unlock_phase: got %0d want %0d", bitPhase, (p0 + 1) % 8);
    end
  endtask

  task automatic test_align_off();
    int p, e, last;
    p = mPhase; e = mErr; last = -1;
    autoAlign = 0;
    txStep();
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL off_unlock: got locked=%b want 0", locked);
    end
    txQ.push_back(1'b1);
    for (int i = 0; i < 60; i++) begin
      txStep();
      vectors++;
      if ({locked, bitPhase, errCount} !== {1'b0, 3'(p), 8'(e)}) begin
        miscompares++;
        $display("FAIL off_hold: got %h want %h", {locked, bitPhase, errCount}, {1'b0, 3'(p), 8'(e)});
      end
      if (wordValid === 1'b1) begin
        if (last >= 0) begin
          vectors++;
          if (i - last != 8) begin
            miscompares++;
            $display("FAIL off_period: got %0d want 8", i - last);
          end
        end
        last = i;
      end
    end
  endtask

  task automatic test_midslip_reset();
    bit hit;
    hit = 0;
    autoAlign = 1;
    for (int i = 0; i < 60 && !hit; i++) begin
      txStep();
      if (mValid && mWordLen == 9) hit = 1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL midslip_find: got no slip in 60 cycles want one");
    end
    rstn = 1'b0; #1;
    vectors++;
    if ({fcOut, word, wordValid, locked, bitPhase, errCount} !== 22'd0) begin
      miscompares++;
      $display("FAIL midslip_clear: got %h want 0", {fcOut, word, wordValid, locked, bitPhase, errCount});
    end
    modelReset();
    @(posedge clk320); #2 rstn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      txStep();
      vectors++;
      if (wordValid !== 1'(k == 8)) begin
        miscompares++;
        $display("FAIL midslip_restart: cycle %0d got valid=%b want %b", k, wordValid, (k == 8));
      end
      vectors++;
      if ({fcOut, word, wordValid, locked, bitPhase, errCount} !==
          {mHist[delaySel], mWord, mValid, mLocked, 3'(mPhase), 8'(mErr)}) begin
        miscompares++;
        $display("FAIL midslip_state: got %h want %h", {fcOut, word, wordValid, locked, bitPhase, errCount},
                 {mHist[delaySel], mWord, mValid, mLocked, 3'(mPhase), 8'(mErr)});
      end
    end
  endtask

  initial begin
    modelReset();
    #2 rstn = 1'b0;
    test_reset();
    test_delay(5);
    test_delay(0);
    test_delay(DEPTH - 1);
    test_align();
    test_commands();
    test_lose_lock();
    test_align_off();
    test_midslip_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
